// File: rtl/zx_gfx_pkg.sv
// Shared definitions for the ZX screen-write capture path.
//   ZX_SCREEN_BASE / ZX_SCREEN_TOP : Z80 address window covering pixels + attributes
//   ZX_ATTR_OFFSET                 : offset of the attribute area inside the window
//   cap_state_t                    : capture FSM states
//   zx_wr_entry_t                  : one queued screen write {offset, data}
package zx_gfx_pkg;

  localparam logic [15:0] ZX_SCREEN_BASE = 16'h4000;
  localparam logic [15:0] ZX_SCREEN_TOP  = 16'h5AFF;
  localparam int          ZX_OFFSET_W    = 13;
  localparam logic [ZX_OFFSET_W-1:0] ZX_ATTR_OFFSET = 13'h1800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [ZX_OFFSET_W-1:0] offset;
    logic [7:0]             data;
  } zx_wr_entry_t;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] top);
    return (addr >= base) && (addr <= top);
  endfunction

endpackage

// File: rtl/zx_bus_write_capture_if.sv
// Write-stream handshake from the capture FIFO head to its consumer.
//   wr_valid : head entry valid
//   wr_ready : consumer accepts the head this cycle
//   wr_addr  : head offset into the screen window
//   wr_data  : head data byte
// master = producer (capture block), slave = consumer (vga_mem).
interface zx_bus_write_capture_if;
  import zx_gfx_pkg::*;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [ZX_OFFSET_W-1:0] wr_addr;
  logic [7:0]             wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (ignored when full unless a pop happens too)
//   pop       : remove head (ignored when empty)
//   pop_data  : head entry; combinational from storage when FWFT=1,
//               registered on pop when FWFT=0
//   level     : entry count, 0..DEPTH
//   full/empty: occupancy flags derived from level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign pop_data = mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] pop_q;
      always_ff @(posedge clk) begin
        if (rst)         pop_q <= '0;
        else if (do_pop) pop_q <= mem[rd_ptr];
      end
      assign pop_data = pop_q;
    end
  endgenerate

endmodule

// File: rtl/zx_bus_write_capture.sv
// Detects Z80 memory writes into the ZX screen window and queues them as
// {offset, data} for the frame-copy writer.
//   clk25, rst : 25 MHz clock, synchronous active-high reset
//   A, D       : Z80 address / data buses (asynchronous)
//   MREQ, WR   : Z80 strobes, active-low (asynchronous)
//   wr_if      : FIFO head stream (master side)
//   fifo_level : current entry count
//   overflow   : sticky, a qualified in-window write was dropped
//
// Capture FSM:
//   state | meaning
//   IDLE  | no write strobe seen on the synchronised pins
//   QUAL  | strobe asserted, counting stable samples before trusting it
//   HOLD  | this strobe already handled, waiting for it to release
module zx_bus_write_capture
  import zx_gfx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = ZX_SCREEN_BASE,
  parameter logic [15:0] TOP_ADDR      = ZX_SCREEN_TOP,
  parameter int          DEPTH         = 8,
  parameter int          STABLE_CYCLES = 2
) (
  input  logic                   clk25,
  input  logic                   rst,
  input  logic [15:0]            A,
  input  logic [7:0]             D,
  input  logic                   MREQ,
  input  logic                   WR,
  zx_bus_write_capture_if.master wr_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int ENTRY_W = $bits(zx_wr_entry_t);
  // Down-counter of samples still needed once in QUAL; capture fires at zero.
  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] QUAL_LOAD =
    CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);

  logic        mreq_s1, mreq_s2;
  logic        wr_s1, wr_s2;
  logic [15:0] a_s1, a_s2;
  logic [7:0]  d_s1, d_s2;
  logic        strobe_s;

  cap_state_t       state, state_nxt;
  logic [CNT_W-1:0] qual_left, qual_left_nxt;
  logic             capture;
  logic             push;
  zx_wr_entry_t     push_entry;
  zx_wr_entry_t     head_entry;

  logic fifo_full;
  logic fifo_empty;
  logic pop;

  // Two-flop synchronisers; reset to the bus-idle level.
  always_ff @(posedge clk25) begin
    if (rst) begin
      mreq_s1 <= 1'b1;
      mreq_s2 <= 1'b1;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      a_s1    <= '0;
      a_s2    <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      mreq_s1 <= MREQ;
      mreq_s2 <= mreq_s1;
      wr_s1   <= WR;
      wr_s2   <= wr_s1;
      a_s1    <= A;
      a_s2    <= a_s1;
      d_s1    <= D;
      d_s2    <= d_s1;
    end
  end

  assign strobe_s = !mreq_s2 && !wr_s2;

  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= IDLE;
      qual_left <= '0;
    end else begin
      state     <= state_nxt;
      qual_left <= qual_left_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    qual_left_nxt = qual_left;
    case (state)
      IDLE: begin
        if (strobe_s) begin
          if (STABLE_CYCLES <= 1) begin
            state_nxt = HOLD;
          end else begin
            state_nxt     = QUAL;
            qual_left_nxt = QUAL_LOAD;
          end
        end
      end
      QUAL: begin
        if (!strobe_s)              state_nxt = IDLE;
        else if (qual_left == '0)   state_nxt = HOLD;
        else                        qual_left_nxt = qual_left - CNT_W'(1);
      end
      HOLD: begin
        if (!strobe_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The capture edge is the one on which the FSM leaves for HOLD; A/D are
  // long stable by then, so the synchronised copies are safe to use.
  always_comb begin
    capture = 1'b0;
    case (state)
      IDLE:    capture = strobe_s && (STABLE_CYCLES <= 1);
      QUAL:    capture = strobe_s && (qual_left == '0);
      default: capture = 1'b0;
    endcase
    push              = capture && in_window(a_s2, BASE_ADDR, TOP_ADDR);
    push_entry.offset = ZX_OFFSET_W'(a_s2 - BASE_ADDR);
    push_entry.data   = d_s2;
  end

  assign pop = wr_if.wr_valid && wr_if.wr_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .clk       (clk25),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_if.wr_valid = !fifo_empty;
  assign wr_if.wr_addr  = head_entry.offset;
  assign wr_if.wr_data  = head_entry.data;

  always_ff @(posedge clk25) begin
    if (rst)                           overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_zx_bus_write_capture.sv
module tb_zx_bus_write_capture;
  import zx_gfx_pkg::*;

  logic        clk25 = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [7:0]  D;
  logic        MREQ;
  logic        WR;
  logic [3:0]  fifo_level;
  logic        overflow;

  zx_bus_write_capture_if bus();

  zx_bus_write_capture #(
    .BASE_ADDR     (16'h4000),
    .TOP_ADDR      (16'h5AFF),
    .DEPTH         (8),
    .STABLE_CYCLES (2)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .A          (A),
    .D          (D),
    .MREQ       (MREQ),
    .WR         (WR),
    .wr_if      (bus),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #20 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int pops = 0;
  zx_wr_entry_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard compare at the negedge before a pop edge, then
  // advance to 1 ns past the rising edge where stimulus is changed.
  task automatic cyc();
    zx_wr_entry_t head;
    @(negedge clk25);
    if (bus.wr_valid) valid_cycles++;
    if (bus.wr_valid && bus.wr_ready) begin
      pops++;
      check("sb_pending", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("sb_addr", 32'(bus.wr_addr), 32'(head.offset));
        check("sb_data", 32'(bus.wr_data), 32'(head.data));
      end
    end
    @(posedge clk25);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pins_write(input logic [15:0] a, input logic [7:0] d, input bit expect_push);
    zx_wr_entry_t e;
    logic [15:0]  off;
    A = a;
    D = d;
    MREQ = 1'b0;
    WR = 1'b0;
    if (expect_push) begin
      off = a - 16'h4000;
      e.offset = off[12:0];
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic pins_release();
    MREQ = 1'b1;
    WR = 1'b1;
  endtask

  task automatic z80_write(input logic [15:0] a, input logic [7:0] d, input int low, input bit expect_push);
    pins_write(a, d, expect_push);
    cycles(low);
    pins_release();
    cycles(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    A = '0;
    D = '0;
    MREQ = 1'b1;
    WR = 1'b1;
    bus.wr_ready = 1'b0;
    cycles(3);
    rst = 1'b0;
    cyc();
    check("rst_valid", 32'(bus.wr_valid), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));

    // Single write, latency to e3 and same-cycle drain.
    bus.wr_ready = 1'b1;
    pins_write(16'h4000, 8'hAA, 1'b1);
    cycles(3);
    check("lat_e2_valid", 32'(bus.wr_valid), 32'(0));
    cyc();
    check("lat_e3_valid", 32'(bus.wr_valid), 32'(1));
    check("lat_e3_addr", 32'(bus.wr_addr), 32'h0000);
    check("lat_e3_data", 32'(bus.wr_data), 32'hAA);
    check("lat_e3_level", 32'(fifo_level), 32'(1));
    cyc();
    check("lat_e4_valid", 32'(bus.wr_valid), 32'(0));
    check("lat_e4_level", 32'(fifo_level), 32'(0));
    cycles(7);
    pins_release();
    cycles(4);

    // Out-of-window writes and a read.
    valid_cycles = 0;
    z80_write(16'h3FFF, 8'h11, 12, 1'b0);
    z80_write(16'h5B00, 8'h22, 12, 1'b0);
    z80_write(16'hFFFF, 8'h33, 12, 1'b0);
    A = 16'h4800;
    D = 8'h44;
    MREQ = 1'b0;
    WR = 1'b1;
    cycles(12);
    pins_release();
    cycles(4);
    check("oow_valid_cycles", 32'(valid_cycles), 32'(0));
    check("oow_overflow", 32'(overflow), 32'(0));

    // One-cycle glitch rejected, then the top address of the window.
    valid_cycles = 0;
    z80_write(16'h5800, 8'h55, 1, 1'b0);
    check("glitch_valid_cycles", 32'(valid_cycles), 32'(0));
    pops = 0;
    z80_write(16'h5AFF, 8'h47, 12, 1'b1);
    check("top_pops", 32'(pops), 32'(1));
    check("top_sb_empty", 32'(exp_q.size()), 32'(0));

    // Overflow: nine writes with the consumer stalled.
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      z80_write(16'h4000 + 16'(i), 8'(i), 12, i < 8);
    check("ovf_level", 32'(fifo_level), 32'(8));
    check("ovf_flag", 32'(overflow), 32'(1));
    bus.wr_ready = 1'b1;
    pops = 0;
    cycles(10);
    check("ovf_drain_pops", 32'(pops), 32'(8));
    check("ovf_drain_sb", 32'(exp_q.size()), 32'(0));
    check("ovf_sticky", 32'(overflow), 32'(1));
    check("ovf_drain_level", 32'(fifo_level), 32'(0));

    // Reset while qualifying a strobe.
    valid_cycles = 0;
    pins_write(16'h4000, 8'h66, 1'b0);
    cycles(3);
    rst = 1'b1;
    pins_release();
    cyc();
    rst = 1'b0;
    check("rstq_valid", 32'(bus.wr_valid), 32'(0));
    check("rstq_level", 32'(fifo_level), 32'(0));
    check("rstq_overflow", 32'(overflow), 32'(0));
    cycles(6);
    check("rstq_no_capture", 32'(valid_cycles), 32'(0));

    // Reset with entries queued, then a normal attribute write.
    bus.wr_ready = 1'b0;
    z80_write(16'h4010, 8'h01, 12, 1'b1);
    z80_write(16'h4020, 8'h02, 12, 1'b1);
    z80_write(16'h4030, 8'h03, 12, 1'b1);
    check("rstf_level_before", 32'(fifo_level), 32'(3));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    check("rstf_valid", 32'(bus.wr_valid), 32'(0));
    check("rstf_level", 32'(fifo_level), 32'(0));
    check("rstf_overflow", 32'(overflow), 32'(0));
    bus.wr_ready = 1'b1;
    pops = 0;
    z80_write(16'h4000 + 16'(ZX_ATTR_OFFSET), 8'h5A, 12, 1'b1);
    cycles(2);
    check("post_rst_pops", 32'(pops), 32'(1));
    check("post_rst_sb", 32'(exp_q.size()), 32'(0));

    // Full FIFO with a pop on the exact push edge.
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      z80_write(16'h4040 + 16'(i), 8'(8'h80 + i), 12, 1'b1);
    check("full_level", 32'(fifo_level), 32'(8));
    pins_write(16'h4100, 8'h99, 1'b1);
    cycles(3);
    bus.wr_ready = 1'b1;
    cyc();
    check("full_pushpop_level", 32'(fifo_level), 32'(8));
    check("full_pushpop_overflow", 32'(overflow), 32'(0));
    cycles(9);
    pins_release();
    cycles(16);
    check("full_drain_sb", 32'(exp_q.size()), 32'(0));
    check("full_drain_level", 32'(fifo_level), 32'(0));
    check("full_final_overflow", 32'(overflow), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
